// File: rtl/jtag_func_ctrl.sv
// JTAG USER1/USER2 function sequencer for the DCFEB user register chain.
// Optional BITCNT_LIMIT_EN enforces exact shift length per data phase.
module jtag_func_ctrl #(
  parameter int         NFUNC    = 8,
  parameter int         REG_W    = 16,
  parameter int         DSY_W    = 64,
  parameter logic [7:0] DSY_CODE = 8'h3F,
  parameter int         CNT_W    = 16
) (
  input  logic             TCK,
  input  logic             RST,
  input  logic             SEL1,
  input  logic             SEL2,
  input  logic             CAPTURE,
  input  logic             SHIFT,
  input  logic             UPDATE,
  input  logic             TDI,
  input  logic [NFUNC-1:0] TDO_IN,
  input  logic             DSY_TDO,
  output logic [NFUNC-1:0] FSEL,
  output logic             DSY_CHAIN,
  output logic             DRCK_EN,
  output logic             UPDATE_OUT,
  output logic             TDO1,
  output logic             TDO2,
  output logic [7:0]       FUNC,
  output logic [CNT_W-1:0] BIT_CNT,
  output logic             ERR
);

  typedef enum logic [1:0] {
    IDLE, ARMED, SHIFTING, DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [7:0]       ir;
  logic [NFUNC-1:0] fsel_dec;
  logic             code_ok;
  logic             code_dsy;
  logic             sel1_ev;
  logic             sel1_upd;
  logic             s2_cap;
  logic             s2_shift;
  logic             s2_upd;
  logic             active;
  logic             len_ok;

  // Any USER1 activity masks USER2 events on the same edge
  assign sel1_ev  = SEL1 & (CAPTURE | SHIFT | UPDATE);
  assign sel1_upd = SEL1 & UPDATE;
  assign s2_cap   = SEL2 & CAPTURE & ~sel1_ev;
  assign s2_shift = SEL2 & SHIFT & ~sel1_ev;
  assign s2_upd   = SEL2 & UPDATE & ~sel1_ev;
  assign active   = (state == ARMED) || (state == SHIFTING);
  assign TDO1     = ir[0];

  always_comb begin
    fsel_dec = '0;
    for (int i = 0; i < NFUNC; i++)
      fsel_dec[i] = (ir == 8'(i + 1));
  end

  assign code_ok  = |fsel_dec;
  assign code_dsy = (ir == DSY_CODE);

`ifdef BITCNT_LIMIT_EN
  logic [CNT_W-1:0] len;
  assign len    = DSY_CHAIN ? CNT_W'(DSY_W) : CNT_W'(REG_W);
  assign len_ok = (BIT_CNT == len);
  assign DRCK_EN = active & (BIT_CNT < len);
`else
  assign len_ok  = 1'b1;
  assign DRCK_EN = active;
`endif

  always_ff @(posedge TCK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (sel1_upd) begin
      state_n = (code_ok || code_dsy) ? ARMED : IDLE;
    end else begin
      unique case (state)
        IDLE:     state_n = IDLE;
        ARMED:
          if (s2_cap)        state_n = ARMED;
          else if (s2_shift) state_n = SHIFTING;
        SHIFTING:
          if (s2_cap)        state_n = ARMED;
          else if (s2_upd)   state_n = DONE;
        DONE:
          if (s2_cap)        state_n = ARMED;
        default:  state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    TDO2 = 1'b0;
    if (state != IDLE)
      TDO2 = |(TDO_IN & FSEL) | (DSY_CHAIN & DSY_TDO);
`ifdef BITCNT_LIMIT_EN
    UPDATE_OUT = UPDATE & SEL2 & (state == SHIFTING) & len_ok;
`else
    UPDATE_OUT = UPDATE & SEL2 & active;
`endif
  end

  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      ir        <= '0;
      FUNC      <= '0;
      FSEL      <= '0;
      DSY_CHAIN <= 1'b0;
      BIT_CNT   <= '0;
      ERR       <= 1'b0;
    end else if (sel1_ev) begin
      if (CAPTURE) ir <= FUNC;
      else if (SHIFT) ir <= {TDI, ir[7:1]};
      if (UPDATE) begin
        FUNC      <= ir;
        BIT_CNT   <= '0;
        FSEL      <= fsel_dec;
        DSY_CHAIN <= code_dsy;
        ERR       <= ~(code_ok | code_dsy | (ir == 8'h00));
      end
    end else if (state != IDLE) begin
      if (s2_cap) begin
        BIT_CNT <= '0;
      end else if (s2_shift && DRCK_EN) begin
        if (BIT_CNT != '1) BIT_CNT <= BIT_CNT + 1'b1;
      end else if (s2_upd && state == SHIFTING && !len_ok) begin
        ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtag_func_ctrl.sv
// Directed bench for jtag_func_ctrl: function load, data phases, errors.
// Expectations follow BITCNT_LIMIT_EN when the bench is built with it.
module tb_jtag_func_ctrl;

  logic        TCK = 1'b0;
  logic        RST = 1'b1;
  logic        SEL1 = 0, SEL2 = 0;
  logic        CAPTURE = 0, SHIFT = 0, UPDATE = 0;
  logic        TDI = 0;
  logic [7:0]  TDO_IN = '0;
  logic        DSY_TDO = 0;
  logic [7:0]  FSEL;
  logic        DSY_CHAIN, DRCK_EN, UPDATE_OUT;
  logic        TDO1, TDO2, ERR;
  logic [7:0]  FUNC;
  logic [15:0] BIT_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  jtag_func_ctrl dut (
    .TCK(TCK), .RST(RST), .SEL1(SEL1), .SEL2(SEL2),
    .CAPTURE(CAPTURE), .SHIFT(SHIFT), .UPDATE(UPDATE),
    .TDI(TDI), .TDO_IN(TDO_IN), .DSY_TDO(DSY_TDO),
    .FSEL(FSEL), .DSY_CHAIN(DSY_CHAIN), .DRCK_EN(DRCK_EN),
    .UPDATE_OUT(UPDATE_OUT), .TDO1(TDO1), .TDO2(TDO2),
    .FUNC(FUNC), .BIT_CNT(BIT_CNT), .ERR(ERR)
  );

  always #5 TCK = ~TCK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge TCK);
    #1;
  endtask

  task automatic load_ir(input logic [7:0] c);
    SEL1 = 1; CAPTURE = 1; tick(); CAPTURE = 0;
    SHIFT = 1;
    for (int i = 0; i < 8; i++) begin
      TDI = c[i]; tick();
    end
    SHIFT = 0; UPDATE = 1; tick(); UPDATE = 0; SEL1 = 0;
  endtask

  task automatic shift_dr(input int n, input logic [63:0] d,
                          output int nd, output int nu,
                          output logic [15:0] c0);
    nd = 0; nu = 0;
    SEL2 = 1; CAPTURE = 1; tick(); CAPTURE = 0;
    c0 = BIT_CNT;
    SHIFT = 1;
    for (int i = 0; i < n; i++) begin
      TDI = d[i % 64]; #1;
      if (DRCK_EN) nd++;
      tick();
    end
    SHIFT = 0; UPDATE = 1; #1;
    if (UPDATE_OUT) nu++;
    tick(); UPDATE = 0; SEL2 = 0;
  endtask

  task automatic test_reset;
    #2;
    n_tests++; if (FSEL !== 8'h00) begin n_fail++; $display("FAIL rst_fsel: got %h want 00", FSEL); end
    n_tests++; if (FUNC !== 8'h00) begin n_fail++; $display("FAIL rst_func: got %h want 00", FUNC); end
    n_tests++; if (BIT_CNT !== 16'd0 || ERR !== 1'b0 || DSY_CHAIN !== 1'b0) begin n_fail++; $display("FAIL rst_misc: got cnt=%0d err=%b dsy=%b want 0", BIT_CNT, ERR, DSY_CHAIN); end
    tick(); tick(); RST = 0; tick();
    load_ir(8'd3);
    SEL2 = 1; CAPTURE = 1; tick(); CAPTURE = 0; SHIFT = 1;
    for (int i = 0; i < 5; i++) begin TDI = i[0]; tick(); end
    n_tests++; if (BIT_CNT !== 16'd5) begin n_fail++; $display("FAIL midshift_cnt: got %0d want 5", BIT_CNT); end
    TDO_IN = 8'hFF; DSY_TDO = 1; SHIFT = 0; UPDATE = 1;
    #2; RST = 1; #1;
    n_tests++; if (FSEL !== 8'h00 || DSY_CHAIN !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sel: got fsel=%h dsy=%b want 0", FSEL, DSY_CHAIN); end
    n_tests++; if (UPDATE_OUT !== 1'b0 || DRCK_EN !== 1'b0) begin n_fail++; $display("FAIL rst_mid_upd: got upd=%b drck=%b want 0", UPDATE_OUT, DRCK_EN); end
    n_tests++; if (TDO2 !== 1'b0 || BIT_CNT !== 16'd0 || FUNC !== 8'h00) begin n_fail++; $display("FAIL rst_mid_out: got tdo2=%b cnt=%0d func=%h want 0", TDO2, BIT_CNT, FUNC); end
    UPDATE = 0; SEL2 = 0; TDO_IN = '0; DSY_TDO = 0;
    tick(); RST = 0; tick();
  endtask

  task automatic test_func_reg;
    int nd, nu; logic [15:0] c0;
    load_ir(8'd3);
    n_tests++; if (FUNC !== 8'd3 || FSEL !== 8'b0000_0100) begin n_fail++; $display("FAIL t2_load: got func=%h fsel=%b want 03 00000100", FUNC, FSEL); end
    TDO_IN = 8'b0000_0100; #1;
    n_tests++; if (TDO2 !== 1'b1) begin n_fail++; $display("FAIL t2_tdo2_hi: got %b want 1", TDO2); end
    TDO_IN = 8'b1111_1011; #1;
    n_tests++; if (TDO2 !== 1'b0) begin n_fail++; $display("FAIL t2_tdo2_lo: got %b want 0", TDO2); end
    TDO_IN = '0;
    shift_dr(16, 64'hBEEF, nd, nu, c0);
    n_tests++; if (nd !== 16 || BIT_CNT !== 16'd16) begin n_fail++; $display("FAIL t2_shift: got drck=%0d cnt=%0d want 16 16", nd, BIT_CNT); end
    n_tests++; if (nu !== 1 || ERR !== 1'b0) begin n_fail++; $display("FAIL t2_update: got upd=%0d err=%b want 1 0", nu, ERR); end
    n_tests++; if (DRCK_EN !== 1'b0) begin n_fail++; $display("FAIL t2_done_drck: got %b want 0", DRCK_EN); end
  endtask

  task automatic test_daisy;
    int nd, nu; logic [15:0] c0;
    load_ir(8'h3F);
    n_tests++; if (DSY_CHAIN !== 1'b1 || FSEL !== 8'h00 || FUNC !== 8'h3F) begin n_fail++; $display("FAIL t3_load: got dsy=%b fsel=%h func=%h want 1 00 3f", DSY_CHAIN, FSEL, FUNC); end
    TDO_IN = 8'hFF; DSY_TDO = 1; #1;
    n_tests++; if (TDO2 !== 1'b1) begin n_fail++; $display("FAIL t3_tdo2_hi: got %b want 1", TDO2); end
    DSY_TDO = 0; #1;
    n_tests++; if (TDO2 !== 1'b0) begin n_fail++; $display("FAIL t3_tdo2_lo: got %b want 0", TDO2); end
    TDO_IN = '0;
    shift_dr(64, 64'h0123_4567_89AB_CDEF, nd, nu, c0);
    n_tests++; if (nd !== 64 || BIT_CNT !== 16'd64 || nu !== 1) begin n_fail++; $display("FAIL t3_shift: got drck=%0d cnt=%0d upd=%0d want 64 64 1", nd, BIT_CNT, nu); end
  endtask

  task automatic test_bad_code;
    int nd, nu; logic [15:0] c0;
    load_ir(8'h20);
    n_tests++; if (ERR !== 1'b1 || FSEL !== 8'h00 || DSY_CHAIN !== 1'b0) begin n_fail++; $display("FAIL t4_err: got err=%b fsel=%h dsy=%b want 1 00 0", ERR, FSEL, DSY_CHAIN); end
    TDO_IN = 8'hFF; DSY_TDO = 1;
    shift_dr(16, 64'hFFFF, nd, nu, c0);
    n_tests++; if (nd !== 0 || nu !== 0 || BIT_CNT !== 16'd0) begin n_fail++; $display("FAIL t4_idle: got drck=%0d upd=%0d cnt=%0d want 0 0 0", nd, nu, BIT_CNT); end
    n_tests++; if (TDO2 !== 1'b0) begin n_fail++; $display("FAIL t4_tdo2: got %b want 0", TDO2); end
    TDO_IN = '0; DSY_TDO = 0;
    load_ir(8'd1);
    n_tests++; if (ERR !== 1'b0 || FSEL !== 8'h01) begin n_fail++; $display("FAIL t4_clear: got err=%b fsel=%h want 0 01", ERR, FSEL); end
  endtask

  task automatic test_length;
    int nd, nu; logic [15:0] c0;
    load_ir(8'd2);
    shift_dr(20, 64'hABCDE, nd, nu, c0);
`ifdef BITCNT_LIMIT_EN
    n_tests++; if (nd !== 16 || BIT_CNT !== 16'd16) begin n_fail++; $display("FAIL t5_over: got drck=%0d cnt=%0d want 16 16", nd, BIT_CNT); end
`else
    n_tests++; if (nd !== 20 || BIT_CNT !== 16'd20) begin n_fail++; $display("FAIL t5_over: got drck=%0d cnt=%0d want 20 20", nd, BIT_CNT); end
`endif
    n_tests++; if (nu !== 1 || ERR !== 1'b0) begin n_fail++; $display("FAIL t5_over_upd: got upd=%0d err=%b want 1 0", nu, ERR); end
    shift_dr(10, 64'h3FF, nd, nu, c0);
    n_tests++; if (c0 !== 16'd0 || nd !== 10 || BIT_CNT !== 16'd10) begin n_fail++; $display("FAIL t5_under: got cap=%0d drck=%0d cnt=%0d want 0 10 10", c0, nd, BIT_CNT); end
`ifdef BITCNT_LIMIT_EN
    n_tests++; if (nu !== 0 || ERR !== 1'b1) begin n_fail++; $display("FAIL t5_under_upd: got upd=%0d err=%b want 0 1", nu, ERR); end
`else
    n_tests++; if (nu !== 1 || ERR !== 1'b0) begin n_fail++; $display("FAIL t5_under_upd: got upd=%0d err=%b want 1 0", nu, ERR); end
`endif
  endtask

  task automatic test_back_to_back;
    int nd, nu; logic [15:0] c0;
    logic [7:0] rb;
    load_ir(8'd2);
    shift_dr(16, 64'h1234, nd, nu, c0);
    n_tests++; if (nu !== 1 || BIT_CNT !== 16'd16) begin n_fail++; $display("FAIL t6_first: got upd=%0d cnt=%0d want 1 16", nu, BIT_CNT); end
    shift_dr(16, 64'h5678, nd, nu, c0);
    n_tests++; if (c0 !== 16'd0 || nu !== 1 || BIT_CNT !== 16'd16) begin n_fail++; $display("FAIL t6_second: got cap=%0d upd=%0d cnt=%0d want 0 1 16", c0, nu, BIT_CNT); end
    load_ir(8'h3F);
    SEL1 = 1; SEL2 = 1; SHIFT = 1; TDI = 1; tick();
    SEL1 = 0; SEL2 = 0; SHIFT = 0;
    n_tests++; if (BIT_CNT !== 16'd0) begin n_fail++; $display("FAIL t6_prio: got cnt=%0d want 0", BIT_CNT); end
    SEL1 = 1; CAPTURE = 1; tick(); CAPTURE = 0; SHIFT = 1;
    rb = '0;
    for (int i = 0; i < 8; i++) begin
      rb[i] = TDO1; TDI = TDO1; tick();
    end
    SHIFT = 0; UPDATE = 1; tick(); UPDATE = 0; SEL1 = 0;
    n_tests++; if (rb !== 8'h3F) begin n_fail++; $display("FAIL t6_readback: got %h want 3f", rb); end
    n_tests++; if (FUNC !== 8'h3F || DSY_CHAIN !== 1'b1 || ERR !== 1'b0) begin n_fail++; $display("FAIL t6_reload: got func=%h dsy=%b err=%b want 3f 1 0", FUNC, DSY_CHAIN, ERR); end
  endtask

  initial begin
    test_reset();
    test_func_reg();
    test_daisy();
    test_bad_code();
    test_length();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
